// File: rtl/shift_seq_arbiter_if.sv
// Request/grant and shift-register drive bundle for shift_seq_arbiter.
// The master side issues transfer requests; the slave side is the arbiter.
interface shift_seq_arbiter_if #(
  parameter int WIDTH = 8
);
  logic [1:0]       req;
  logic             dir0;
  logic             dir1;
  logic [WIDTH-1:0] word0;
  logic [WIDTH-1:0] word1;
  logic             abort;
  logic [1:0]       gnt;
  logic             busy;
  logic             done;
  logic             done_id;
  logic             shift_left;
  logic             shift_right;
  logic             data_in;

  modport master (
    output req, dir0, dir1, word0, word1, abort,
    input  gnt, busy, done, done_id, shift_left, shift_right, data_in
  );

  modport slave (
    input  req, dir0, dir1, word0, word1, abort,
    output gnt, busy, done, done_id, shift_left, shift_right, data_in
  );
endinterface

// File: rtl/shift_seq_arbiter.sv
// Two-requester round-robin arbiter that serially loads the winner's word
// into an external shift register, MSB first when shifting left and LSB
// first when shifting right. All outputs decode from registered state.
module shift_seq_arbiter #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                reset,
  shift_seq_arbiter_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_owner;
  logic             r_last;
  logic [WIDTH-1:0] r_word;
  logic             r_dir;
  logic             w_start;
  logic             w_sel;
  logic [CNT_W-1:0] w_idx;

  assign w_start = (r_state == S_IDLE) && (bus.req != 2'b00);

  // Bit position of the word presented this cycle: LSB-up for right, MSB-down for left.
  assign w_idx = r_dir ? r_cnt : (CNT_LAST - r_cnt);

  // Winner selection: a lone requester wins, contention goes to the one not served last.
  always_comb begin
    w_sel = 1'b0;
    case (bus.req)
      2'b01:   w_sel = 1'b0;
      2'b10:   w_sel = 1'b1;
      2'b11:   w_sel = ~r_last;
      default: w_sel = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; abort only matters while shifting, req only while idle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.req != 2'b00) w_next = S_SHIFT;
      S_SHIFT: begin
        if (bus.abort)               w_next = S_IDLE;
        else if (r_cnt == CNT_LAST)  w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Transfer context: owner/word/dir captured at the grant edge, bit counter,
  // and last-served pointer which moves only on a completed transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_word  <= '0;
      r_dir   <= 1'b0;
    end else begin
      if (w_start) begin
        r_owner <= w_sel;
        r_word  <= w_sel ? bus.word1 : bus.word0;
        r_dir   <= w_sel ? bus.dir1 : bus.dir0;
        r_cnt   <= '0;
      end else if (r_state == S_SHIFT) begin
        r_cnt   <= r_cnt + CNT_W'(1);
      end
      if (r_state == S_DONE) begin
        r_last  <= r_owner;
      end
    end
  end

  // Output decode from registered state only.
  always_comb begin
    bus.gnt         = 2'b00;
    bus.busy        = 1'b0;
    bus.done        = 1'b0;
    bus.done_id     = 1'b0;
    bus.shift_left  = 1'b0;
    bus.shift_right = 1'b0;
    bus.data_in     = 1'b0;
    case (r_state)
      S_SHIFT: begin
        bus.busy        = 1'b1;
        bus.gnt         = (r_cnt == '0) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
        bus.shift_left  = ~r_dir;
        bus.shift_right = r_dir;
        bus.data_in     = r_word[w_idx];
      end
      S_DONE: begin
        bus.busy    = 1'b1;
        bus.done    = 1'b1;
        bus.done_id = r_owner;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_shift_seq_arbiter.sv
// Bench for shift_seq_arbiter: directed transfers with expected grants and
// completions queued by the stimulus and checked by an independent monitor
// that models the external shift register.
module tb_shift_seq_arbiter;

  localparam int WIDTH = 8;

  typedef struct {
    logic id;
    int   gap;
  } gnt_t;

  typedef struct {
    logic             id;
    logic [WIDTH-1:0] word;
    logic             dir;
  } xfer_t;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   n_done   = 0;

  gnt_t  gnt_q[$];
  xfer_t exp_q[$];
  gnt_t  g;
  xfer_t x;

  logic [WIDTH-1:0] sreg = '0;
  int   n_left       = 0;
  int   n_right      = 0;
  int   last_gnt_cyc = 0;
  bit   abort_seen   = 1'b0;

  shift_seq_arbiter_if #(.WIDTH(WIDTH)) bus ();

  shift_seq_arbiter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples on the falling edge, models the external register.
  always @(negedge clk) begin
    if (!reset) begin
      check("reset_outputs",
            32'({bus.gnt, bus.busy, bus.done, bus.done_id,
                 bus.shift_left, bus.shift_right, bus.data_in}), 32'd0);
      abort_seen = 1'b0;
    end else begin
      check("strobe_exclusive", 32'(bus.shift_left & bus.shift_right), 32'd0);
      check("strobe_outside_shift",
            32'((bus.shift_left | bus.shift_right) & (~bus.busy | bus.done)), 32'd0);
      check("data_in_idle",
            32'(bus.data_in & ~(bus.shift_left | bus.shift_right)), 32'd0);
      if (abort_seen)
        check("abort_quiet",
              32'({bus.shift_left, bus.shift_right, bus.busy, bus.done}), 32'd0);
      abort_seen = bus.abort & (bus.shift_left | bus.shift_right);

      if (bus.gnt != 2'b00) begin
        if (gnt_q.size() == 0) begin
          check("unexpected_gnt", 32'(bus.gnt), 32'd0);
        end else begin
          g = gnt_q.pop_front();
          check("gnt_value", 32'(bus.gnt), g.id ? 32'd2 : 32'd1);
          if (g.gap != 0) check("gnt_spacing", 32'(cyc - last_gnt_cyc), 32'(g.gap));
        end
        last_gnt_cyc = cyc;
        n_left  = 0;
        n_right = 0;
      end

      if (bus.shift_left) begin
        sreg = {sreg[WIDTH-2:0], bus.data_in};
        n_left++;
      end
      if (bus.shift_right) begin
        sreg = {bus.data_in, sreg[WIDTH-1:1]};
        n_right++;
      end

      if (bus.done) begin
        n_done++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          x = exp_q.pop_front();
          check("done_id", 32'(bus.done_id), 32'(x.id));
          check("register", 32'(sreg), 32'(x.word));
          check("strobe_count", 32'(x.dir ? n_right : n_left), 32'(WIDTH));
          check("wrong_dir_strobes", 32'(x.dir ? n_left : n_right), 32'd0);
          check("done_latency", 32'(cyc - last_gnt_cyc), 32'(WIDTH));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present req for one sampling edge; returns inside the grant cycle.
  task automatic start(input logic [1:0] r);
    bus.req = r;
    tick();
    bus.req = 2'b00;
  endtask

  task automatic wait_done(input int target);
    int i = 0;
    while (n_done < target && i < 100) begin
      tick();
      i++;
    end
    check("done_timeout", 32'(n_done >= target), 32'd1);
  endtask

  task automatic exp_gnt(input logic id, input int gap);
    gnt_t e;
    e.id  = id;
    e.gap = gap;
    gnt_q.push_back(e);
  endtask

  task automatic exp_xfer(input logic id, input logic [WIDTH-1:0] word, input logic dir);
    xfer_t e;
    e.id   = id;
    e.word = word;
    e.dir  = dir;
    exp_q.push_back(e);
  endtask

  initial begin
    reset     = 1'b0;
    bus.req   = 2'b00;
    bus.dir0  = 1'b0;
    bus.dir1  = 1'b0;
    bus.word0 = '0;
    bus.word1 = '0;
    bus.abort = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // Single left transfer from requester 0.
    bus.word0 = 8'hA5; bus.dir0 = 1'b0;
    exp_gnt(1'b0, 0); exp_xfer(1'b0, 8'hA5, 1'b0);
    start(2'b01);
    wait_done(1);

    // Single right transfer from requester 1.
    bus.word1 = 8'h3C; bus.dir1 = 1'b1;
    exp_gnt(1'b1, 0); exp_xfer(1'b1, 8'h3C, 1'b1);
    start(2'b10);
    wait_done(2);

    // Contention held for four transfers: alternating owners, WIDTH+2 spacing.
    bus.word0 = 8'h11; bus.dir0 = 1'b1;
    bus.word1 = 8'h8E; bus.dir1 = 1'b0;
    exp_gnt(1'b0, 0);         exp_xfer(1'b0, 8'h11, 1'b1);
    exp_gnt(1'b1, WIDTH + 2); exp_xfer(1'b1, 8'h8E, 1'b0);
    exp_gnt(1'b0, WIDTH + 2); exp_xfer(1'b0, 8'h11, 1'b1);
    exp_gnt(1'b1, WIDTH + 2); exp_xfer(1'b1, 8'h8E, 1'b0);
    bus.req = 2'b11;
    wait_done(6);
    bus.req = 2'b00;

    // Word and dir change after the grant must not affect the transfer.
    bus.word0 = 8'hFF; bus.dir0 = 1'b0;
    exp_gnt(1'b0, 0); exp_xfer(1'b0, 8'hFF, 1'b0);
    start(2'b01);
    tick();
    bus.word0 = 8'h00; bus.dir0 = 1'b1;
    wait_done(7);

    // Abort in the 4th shift cycle; pointer stays at 0 so requester 1 wins again.
    bus.word1 = 8'h5A; bus.dir1 = 1'b1;
    exp_gnt(1'b1, 0);
    start(2'b11);
    tick(); tick(); tick();
    bus.abort = 1'b1;
    tick();
    // abort together with req while idle is a normal grant
    bus.req = 2'b11;
    exp_gnt(1'b1, 0); exp_xfer(1'b1, 8'h5A, 1'b1);
    tick();
    bus.abort = 1'b0;
    bus.req   = 2'b00;
    wait_done(8);

    // Requester 0 completes, moving the pointer to 0.
    bus.word0 = 8'hC3; bus.dir0 = 1'b1;
    exp_gnt(1'b0, 0); exp_xfer(1'b0, 8'hC3, 1'b1);
    start(2'b01);
    wait_done(9);

    // Reset in the 3rd shift cycle abandons the transfer and restores pointer 1.
    exp_gnt(1'b0, 0);
    start(2'b01);
    tick(); tick();
    reset = 1'b0;
    tick(); tick();
    bus.word0 = 8'h96; bus.dir0 = 1'b0;
    bus.req = 2'b11;
    reset   = 1'b1;
    exp_gnt(1'b0, 0); exp_xfer(1'b0, 8'h96, 1'b0);
    tick();
    bus.req = 2'b00;
    wait_done(10);

    repeat (4) tick();
    check("gnt_queue_empty", 32'(gnt_q.size()), 32'd0);
    check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/shift_seq_arbiter.md
SHIFT_SEQ_ARBITER -- requirements
Module: shift_seq_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the shift-register width and the number of bits per transfer.
REQ-002 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port req, input, 2, per-requester transfer request, level, held until grant.
REQ-005 The block SHALL have port dir0 / dir1, input, 1 each, per-requester direction: 0 = shift left, 1 = shift right.
REQ-006 The block SHALL have port word0 / word1, input, WIDTH each, per-requester word to load serially.
REQ-007 The block SHALL have port abort, input, 1, synchronous cancel of the transfer in progress.
REQ-008 The block SHALL have port gnt, output, 2, one-hot one-cycle grant pulse.
REQ-009 The block SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-010 The block SHALL have port done, output, 1, one-cycle completion pulse.
REQ-011 The block SHALL have port done_id, output, 1, index of the requester whose transfer completed, valid while done is high.
REQ-012 The block SHALL have port shift_left / shift_right / data_in, output, 1 each, drive for the 8-bit shift register.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-014 In IDLE with req != 0 at a clock edge, the FSM SHALL select an owner, latch its word and dir, clear the bit counter cnt and enter SHIFT.
REQ-015 With a single requester active, the block SHALL grant that requester.
REQ-016 With both requesters active, the block SHALL grant the requester not served last (round-robin).
REQ-017 The last-served pointer SHALL reset to 1, so requester 0 wins the first contention.
REQ-018 gnt[owner] SHALL be high for exactly the first SHIFT cycle, and gnt SHALL be 0 in every other cycle.
REQ-019 The block SHALL sample word and dir only at the grant edge; later changes SHALL have no effect on the transfer in progress.
REQ-020 In SHIFT, exactly one of shift_left / shift_right SHALL be high, per the latched dir, for exactly WIDTH consecutive cycles; cnt SHALL count 0..WIDTH-1.
REQ-021 For left transfers, data_in SHALL equal word[WIDTH-1-cnt] (MSB first).
REQ-022 For right transfers, data_in SHALL equal word[cnt] (LSB first).
REQ-023 After a completed transfer, the shift register SHALL hold the latched word exactly.
REQ-024 At the edge ending cnt = WIDTH-1, the FSM SHALL enter DONE.
REQ-025 In DONE, done SHALL be 1 and done_id SHALL equal the owner; the pointer SHALL update to the owner; the FSM SHALL return to IDLE on the next edge.
REQ-026 In IDLE and DONE, shift_left, shift_right and data_in SHALL be 0.
REQ-027 In IDLE and DONE, req SHALL be ignored in DONE.
REQ-028 Timing SHALL be as follows: req sampled at edge k; gnt and shifts in cycles k+1..k+WIDTH; done in cycle k+WIDTH+1; IDLE in cycle k+WIDTH+2.
REQ-029 The earliest next grant cycle SHALL be k+WIDTH+3.
REQ-030 abort high at an edge while in SHIFT SHALL force IDLE.
REQ-031 After an abort, shift strobes SHALL be 0 from the next cycle, no done pulse SHALL be issued, and the pointer SHALL be unchanged.
REQ-032 abort SHALL be ignored in IDLE and DONE.
REQ-033 abort and req in the same IDLE cycle SHALL be treated as a normal grant.
REQ-034 The shift strobes SHALL never be high outside SHIFT.
REQ-035 shift_left and shift_right SHALL never be high together.
REQ-036 All outputs SHALL be decoded from registered state only, with no combinational path from req, dir or word to gnt or the shift strobes.

Reset
REQ-037 reset low SHALL asynchronously force the following: state IDLE, cnt 0, pointer 1, latched word 0, latched dir 0.
REQ-038 During reset, the outputs SHALL be gnt = 00, busy = 0, done = 0, done_id = 0, shift_left = shift_right = data_in = 0.
REQ-039 Reset asserted mid-transfer SHALL abandon the transfer with no done pulse.
REQ-040 Release of reset SHALL take effect at the first following rising edge with reset high.

Verification
REQ-041 Single left transfer: req = 01, dir0 = 0, word0 = 8'hA5 -> gnt = 01 for one cycle; shift_left high for 8 cycles; data_in = 1,0,1,0,0,1,0,1; register = A5; done with done_id = 0 at cycle k+9.
REQ-042 Single right transfer: req = 10, dir1 = 1, word1 = 8'h3C -> shift_right high for 8 cycles; data_in = 0,0,1,1,1,1,0,0; register = 3C; done_id = 1.
REQ-043 Contention: req = 11 held constantly from reset -> grants alternate 01, 10, 01, 10; done_id sequence 0,1,0,1; grant spacing of WIDTH+2 cycles.
REQ-044 Word change after grant: word0 changes from 8'hFF to 8'h00 in cycle k+2 -> register still = FF at completion.
REQ-045 Abort: abort pulsed in the 4th SHIFT cycle -> strobes low next cycle; no done; next contention grant goes to the same requester as before the aborted transfer.
REQ-046 Reset mid-transfer: reset low in the 3rd SHIFT cycle -> all outputs 0 immediately; after release with req = 11, the first grant is 01.
